// File: rtl/fifo_hs_pkg.sv
// fifo_hs_pkg: width helper shared by the FIFO and its pointer counters.
package fifo_hs_pkg;

  // Bits needed to index 0..n-1; never less than one bit.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_hs_if.sv
// fifo_hs_if: ready/valid handshake bundle around the FIFO.
// slave is the FIFO side, master is the producer/consumer side.
interface fifo_hs_if #(
  parameter type DATA_T = logic [7:0],
  parameter int  DEPTH  = 4
);
  logic                         valid_i;
  logic                         ready_o;
  DATA_T                        data_i;
  logic                         valid_o;
  logic                         ready_i;
  DATA_T                        data_o;
  logic [$clog2(DEPTH+1)-1:0]   count_o;

  modport slave (
    input  valid_i, data_i, ready_i,
    output ready_o, valid_o, data_o, count_o
  );

  modport master (
    output valid_i, data_i, ready_i,
    input  ready_o, valid_o, data_o, count_o
  );
endinterface

// File: rtl/fifo_hs_modn_counter.sv
// modn_counter: wrapping 0..N-1 counter with synchronous clear and enable.
module modn_counter
  import fifo_hs_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    clr_i,
  input  logic                    en_i,
  output logic [ptr_width(N)-1:0] cnt_o
);
  localparam int W = ptr_width(N);

  // Clear wins over enable; wrap from N-1 back to zero.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      cnt_o <= '0;
    else if (clr_i)
      cnt_o <= '0;
    else if (en_i)
      cnt_o <= (cnt_o == W'(N - 1)) ? '0 : cnt_o + 1'b1;
  end
endmodule

// File: rtl/fifo_hs.sv
// fifo_hs: DEPTH-entry ready/valid FIFO, one-cycle write-to-read latency.
// Define FIFO_HS_BYPASS_EN to let data fall through an empty FIFO in zero
// cycles; with it undefined the FIFO is a plain registered queue.
module fifo_hs
  import fifo_hs_pkg::*;
#(
  parameter type DATA_T = logic [7:0],
  parameter int  DEPTH  = 4
) (
  input  logic     clk_i,
  input  logic     rst_n_i,
  input  logic     flush_i,
  fifo_hs_if.slave bus
);
  localparam int PW = ptr_width(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  DATA_T           mem [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            pass;
  logic            wr;
  logic            rd;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // ready_o depends only on registered occupancy, never on ready_i.
  assign bus.ready_o = !full;
  assign bus.count_o = count;

`ifdef FIFO_HS_BYPASS_EN
  // Empty FIFO presents the producer directly; a same-cycle take skips storage.
  assign pass        = empty && bus.valid_i && bus.ready_i;
  assign bus.valid_o = empty ? bus.valid_i : 1'b1;
  assign bus.data_o  = empty ? bus.data_i  : mem[head];
`else
  assign pass        = 1'b0;
  assign bus.valid_o = !empty;
  assign bus.data_o  = mem[head];
`endif

  assign push = bus.valid_i && bus.ready_o;
  assign pop  = bus.valid_o && bus.ready_i;
  assign wr   = push && !pass && !flush_i;
  assign rd   = pop  && !pass && !flush_i;

  modn_counter #(.N(DEPTH)) u_head (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr_i   (flush_i),
    .en_i    (rd),
    .cnt_o   (head)
  );

  modn_counter #(.N(DEPTH)) u_tail (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr_i   (flush_i),
    .en_i    (wr),
    .cnt_o   (tail)
  );

  // Storage: cleared only by reset; flush just rewinds the pointers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (wr) begin
      mem[tail] <= bus.data_i;
    end
  end

  // Occupancy: net zero on simultaneous write and read.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      count <= '0;
    else if (flush_i)
      count <= '0;
    else if (wr && !rd)
      count <= count + 1'b1;
    else if (rd && !wr)
      count <= count - 1'b1;
  end

`ifndef SYNTHESIS
  a_no_push_full : assert property (@(posedge clk_i) disable iff (!rst_n_i)
                                    full |-> !wr);
  a_no_pop_empty : assert property (@(posedge clk_i) disable iff (!rst_n_i)
                                    empty |-> !rd);
  a_count_range  : assert property (@(posedge clk_i) disable iff (!rst_n_i)
                                    count <= CW'(DEPTH));
`endif
endmodule

// File: tb/tb_fifo_hs.sv
// tb_fifo_hs: directed scenarios for fifo_hs with DATA_T 8-bit, DEPTH 4.
module tb_fifo_hs;
  logic clk;
  logic rst_n;
  logic flush;
  int   tests;
  int   fails;

  fifo_hs_if #(.DATA_T(logic [7:0]), .DEPTH(4)) bus ();

  fifo_hs #(.DATA_T(logic [7:0]), .DEPTH(4)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .flush_i (flush),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0;
    bus.valid_i = 1'b0; bus.ready_i = 1'b0; bus.data_i = 8'h00;
    #2;
    tests++; if (bus.valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid_o got %b want 0", bus.valid_o); end
    tests++; if (bus.ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready_o got %b want 1", bus.ready_o); end
    tests++; if (bus.count_o !== 3'd0) begin fails++; $display("FAIL reset_count_o got %0d want 0", bus.count_o); end
    tests++; if (bus.data_o !== 8'h00) begin fails++; $display("FAIL reset_data_o got %h want 00", bus.data_o); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    tests++; if (bus.count_o !== 3'd0) begin fails++; $display("FAIL post_reset_count got %0d want 0", bus.count_o); end
  endtask

  task automatic test_fill();
    logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    bus.ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.valid_i = 1'b1; bus.data_i = vals[i];
      tick();
      tests++; if (bus.count_o !== 3'(i + 1)) begin fails++; $display("FAIL fill_count[%0d] got %0d want %0d", i, bus.count_o, i + 1); end
      tests++; if (bus.valid_o !== 1'b1 || bus.data_o !== 8'h11) begin fails++; $display("FAIL fill_head[%0d] got v=%b d=%h want v=1 d=11", i, bus.valid_o, bus.data_o); end
    end
    tests++; if (bus.ready_o !== 1'b0) begin fails++; $display("FAIL full_ready_o got %b want 0", bus.ready_o); end
    bus.data_i = 8'h55;
    tick();
    bus.valid_i = 1'b0;
    tests++; if (bus.count_o !== 3'd4) begin fails++; $display("FAIL overflow_count got %0d want 4", bus.count_o); end
    tests++; if (bus.data_o !== 8'h11) begin fails++; $display("FAIL overflow_head got %h want 11", bus.data_o); end
  endtask

  task automatic test_drain();
    logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    bus.valid_i = 1'b0; bus.ready_i = 1'b1;
    #1;
    tests++; if (bus.ready_o !== 1'b0) begin fails++; $display("FAIL pop_cycle_ready_o got %b want 0", bus.ready_o); end
    for (int i = 0; i < 4; i++) begin
      tests++; if (bus.valid_o !== 1'b1 || bus.data_o !== vals[i]) begin fails++; $display("FAIL drain_data[%0d] got v=%b d=%h want v=1 d=%h", i, bus.valid_o, bus.data_o, vals[i]); end
      tick();
      tests++; if (bus.count_o !== 3'(3 - i)) begin fails++; $display("FAIL drain_count[%0d] got %0d want %0d", i, bus.count_o, 3 - i); end
      if (i == 0) begin
        tests++; if (bus.ready_o !== 1'b1) begin fails++; $display("FAIL after_pop_ready_o got %b want 1", bus.ready_o); end
      end
    end
    bus.ready_i = 1'b0;
    tests++; if (bus.valid_o !== 1'b0) begin fails++; $display("FAIL drained_valid_o got %b want 0", bus.valid_o); end
  endtask

  task automatic test_stream();
    bus.ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.valid_i = 1'b1; bus.data_i = 8'(i);
      #1;
      if (i > 0) begin
        tests++; if (bus.valid_o !== 1'b1 || bus.data_o !== 8'(i - 1)) begin fails++; $display("FAIL stream_data[%0d] got v=%b d=%h want v=1 d=%h", i, bus.valid_o, bus.data_o, 8'(i - 1)); end
      end
      tick();
      tests++; if (bus.count_o !== 3'd1) begin fails++; $display("FAIL stream_count[%0d] got %0d want 1", i, bus.count_o); end
    end
    bus.valid_i = 1'b0;
    #1;
    tests++; if (bus.data_o !== 8'h09) begin fails++; $display("FAIL stream_last got %h want 09", bus.data_o); end
    tick();
    bus.ready_i = 1'b0;
    tests++; if (bus.count_o !== 3'd0 || bus.valid_o !== 1'b0) begin fails++; $display("FAIL stream_end got c=%0d v=%b want c=0 v=0", bus.count_o, bus.valid_o); end
  endtask

  task automatic test_flush();
    bus.ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.valid_i = 1'b1; bus.data_i = 8'hA0 + 8'(i);
      tick();
    end
    tests++; if (bus.count_o !== 3'd3) begin fails++; $display("FAIL preflush_count got %0d want 3", bus.count_o); end
    flush = 1'b1; bus.data_i = 8'hEE;
    tick();
    flush = 1'b0; bus.valid_i = 1'b0;
    tests++; if (bus.count_o !== 3'd0) begin fails++; $display("FAIL flush_count got %0d want 0", bus.count_o); end
    tests++; if (bus.valid_o !== 1'b0) begin fails++; $display("FAIL flush_valid_o got %b want 0", bus.valid_o); end
    tests++; if (bus.ready_o !== 1'b1) begin fails++; $display("FAIL flush_ready_o got %b want 1", bus.ready_o); end
    bus.valid_i = 1'b1; bus.data_i = 8'h5A;
    tick();
    bus.valid_i = 1'b0;
    tests++; if (bus.count_o !== 3'd1 || bus.data_o !== 8'h5A) begin fails++; $display("FAIL postflush_push got c=%0d d=%h want c=1 d=5a", bus.count_o, bus.data_o); end
    bus.ready_i = 1'b1;
    tick();
    bus.ready_i = 1'b0;
  endtask

  task automatic test_async_reset();
    bus.ready_i = 1'b0;
    bus.valid_i = 1'b1; bus.data_i = 8'hC1; tick();
    bus.data_i = 8'hC2; tick();
    tests++; if (bus.count_o !== 3'd2) begin fails++; $display("FAIL prereset_count got %0d want 2", bus.count_o); end
    bus.data_i = 8'hC3;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    tests++; if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1) begin fails++; $display("FAIL async_handshake got v=%b r=%b want v=0 r=1", bus.valid_o, bus.ready_o); end
    tests++; if (bus.count_o !== 3'd0 || bus.data_o !== 8'h00) begin fails++; $display("FAIL async_state got c=%0d d=%h want c=0 d=00", bus.count_o, bus.data_o); end
    tick();
    bus.valid_i = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tests++; if (bus.count_o !== 3'd0 || bus.valid_o !== 1'b0) begin fails++; $display("FAIL after_async got c=%0d v=%b want c=0 v=0", bus.count_o, bus.valid_o); end
  endtask

`ifdef FIFO_HS_BYPASS_EN
  task automatic test_bypass();
    bus.valid_i = 1'b1; bus.data_i = 8'hA5; bus.ready_i = 1'b1;
    #1;
    tests++; if (bus.valid_o !== 1'b1 || bus.data_o !== 8'hA5) begin fails++; $display("FAIL bypass_same_cycle got v=%b d=%h want v=1 d=a5", bus.valid_o, bus.data_o); end
    tick();
    tests++; if (bus.count_o !== 3'd0) begin fails++; $display("FAIL bypass_count got %0d want 0", bus.count_o); end
    bus.ready_i = 1'b0; bus.data_i = 8'h5B;
    tick();
    bus.valid_i = 1'b0;
    tests++; if (bus.count_o !== 3'd1 || bus.data_o !== 8'h5B) begin fails++; $display("FAIL bypass_stall_write got c=%0d d=%h want c=1 d=5b", bus.count_o, bus.data_o); end
    bus.ready_i = 1'b1;
    tick();
    bus.ready_i = 1'b0;
  endtask
`else
  task automatic test_latency();
    bus.valid_i = 1'b1; bus.data_i = 8'h3C; bus.ready_i = 1'b1;
    #1;
    tests++; if (bus.valid_o !== 1'b0) begin fails++; $display("FAIL latency_same_cycle got v=%b want 0", bus.valid_o); end
    tick();
    bus.valid_i = 1'b0;
    tests++; if (bus.valid_o !== 1'b1 || bus.data_o !== 8'h3C || bus.count_o !== 3'd1) begin fails++; $display("FAIL latency_next got v=%b d=%h c=%0d want v=1 d=3c c=1", bus.valid_o, bus.data_o, bus.count_o); end
    tick();
    bus.ready_i = 1'b0;
    tests++; if (bus.count_o !== 3'd0) begin fails++; $display("FAIL latency_drain got %0d want 0", bus.count_o); end
  endtask
`endif

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_fill();
    test_drain();
    test_stream();
    test_flush();
    test_async_reset();
`ifdef FIFO_HS_BYPASS_EN
    test_bypass();
`else
    test_latency();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
